// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and serializer state encoding.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;
  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } tx_state_e;
endpackage

// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: valid/ready byte write handshake into uart_tx_buffer.
interface uart_tx_buffer_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  modport master (output txData, txValid, input txReady);
  modport slave  (input txData, txValid, output txReady);
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: power-of-two byte FIFO with wrapping pointers and occupancy count.
module uart_byte_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     full,
  output logic                     empty
);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  logic [7:0] mem_q [2**FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q + {{FIFO_DEPTH_LOG2{1'b0}}, push} - {{FIFO_DEPTH_LOG2{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: FIFO-buffered 8N1 UART transmitter, one bit per uartClk.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_buffer #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     uartClk,
  input  logic                     nReset,
  uart_tx_buffer_if.slave          bus,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifoCount
);
  import uart_pkg::*;
  localparam logic [FIFO_DEPTH_LOG2:0] ALMOST_FULL = {1'b0, {FIFO_DEPTH_LOG2{1'b1}}};
  tx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic tx_q, tx_d, busy_q, busy_d, ready_q, ready_d;
  logic push, pop, full, empty;
  logic [7:0] head;
  logic [FIFO_DEPTH_LOG2:0] count;
  assign push = bus.txValid && ready_q;
  assign pop  = (state_q == ST_IDLE || state_q == ST_STOP) && !empty;
  uart_byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk(uartClk), .rst_n(nReset), .push(push), .pop(pop), .din(bus.txData),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge uartClk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = pop ? ST_START : ST_IDLE;
      ST_START:  state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   state_d = (cnt_q == 3'(DATA_BITS - 1)) ? ST_PARITY : ST_DATA;
      ST_PARITY: state_d = ST_STOP;
`else
      ST_DATA:   state_d = (cnt_q == 3'(DATA_BITS - 1)) ? ST_STOP : ST_DATA;
`endif
      ST_STOP:   state_d = pop ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  // tx/busy are computed from the next state so the line flop changes on the transition edge
  always_comb begin
    shift_d = pop ? head : shift_q;
    cnt_d   = (state_q == ST_DATA) ? cnt_q + 3'd1 : 3'd0;
    busy_d  = state_d != ST_IDLE;
`ifdef UART_TX_PARITY_EN
    tx_d    = (state_d == ST_START)  ? START_BIT :
              (state_d == ST_DATA)   ? shift_d[cnt_d] :
              (state_d == ST_PARITY) ? ^shift_q :
              (state_d == ST_IDLE)   ? IDLE_LEVEL : STOP_BIT;
`else
    tx_d    = (state_d == ST_START) ? START_BIT :
              (state_d == ST_DATA)  ? shift_d[cnt_d] :
              (state_d == ST_IDLE)  ? IDLE_LEVEL : STOP_BIT;
`endif
    ready_d = full ? pop : !(push && !pop && count == ALMOST_FULL);
  end
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign bus.txReady = ready_q;
  assign fifoCount   = count;
endmodule
